// File: rtl/dmem_hs_ctrl.sv
// Handshaked RV32 data memory: byte-lane word RAM, one outstanding request,
// RD_LATENCY-cycle loads, alignment/range error responses held until rsp_ready_i.
module dmem_hs_ctrl #(
    parameter int ADDR_WIDTH  = 16,
    parameter int RD_LATENCY  = 1,
    parameter int CHECK_ALIGN = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wr_en_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_zero_extend_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wr_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rd_data_o,
    output logic [1:0]  rsp_err_o
);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam int         IW      = ADDR_WIDTH - 2;
    localparam logic [2:0] LAST    = 3'(RD_LATENCY - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  err_q, err_d;

    logic [31:0] mem_q [0:(2**IW)-1];

    logic                  accept;
    logic                  is_half, is_word;
    logic                  mis, oor;
    logic [1:0]            err_code;
    logic [ADDR_WIDTH-1:0] addr_eff;
    logic [1:0]            lane;
    logic [IW-1:0]         idx;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [31:0]           rd_sh;
    logic [31:0]           ld_data;

    assign req_ready_o   = rst_ni && (state_q == ST_IDLE);
    assign accept        = req_valid_i && req_ready_o;
    assign rsp_valid_o   = (state_q == ST_RESP);
    assign rsp_rd_data_o = data_q;
    assign rsp_err_o     = err_q;

    assign is_half = (req_size_i == SZ_HALF);
    assign is_word = (req_size_i != SZ_BYTE) && !is_half;

    assign mis      = (CHECK_ALIGN != 0) &&
                      ((is_half && req_addr_i[0]) || (is_word && (req_addr_i[1:0] != 2'b00)));
    assign oor      = (req_addr_i >> ADDR_WIDTH) != 32'd0;
    assign err_code = mis ? 2'b01 : (oor ? 2'b10 : 2'b00);

    // With alignment checking off, low address bits are dropped instead of faulting.
    always_comb begin
        addr_eff = req_addr_i[ADDR_WIDTH-1:0];
        if (CHECK_ALIGN == 0) begin
            if (is_half) begin
                addr_eff[0] = 1'b0;
            end else if (is_word) begin
                addr_eff[1:0] = 2'b00;
            end
        end
    end

    assign lane  = addr_eff[1:0];
    assign idx   = addr_eff[ADDR_WIDTH-1:2];
    assign wdata = req_wr_data_i << {lane, 3'b000};
    assign rd_sh = mem_q[idx] >> {lane, 3'b000};

    always_comb begin
        be      = 4'b1111;
        ld_data = rd_sh;
        if (req_size_i == SZ_BYTE) begin
            be      = 4'b0001 << lane;
            ld_data = req_zero_extend_i ? {24'd0, rd_sh[7:0]}
                                        : {{24{rd_sh[7]}}, rd_sh[7:0]};
        end else if (is_half) begin
            be      = lane[1] ? 4'b1100 : 4'b0011;
            ld_data = req_zero_extend_i ? {16'd0, rd_sh[15:0]}
                                        : {{16{rd_sh[15]}}, rd_sh[15:0]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && req_wr_en_i && (err_code == 2'b00)) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Load data is captured at accept; with one outstanding request the RAM
    // cannot change underneath it, so WAIT only has to count out the latency.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    err_d  = err_code;
                    data_d = (req_wr_en_i || (err_code != 2'b00)) ? 32'd0 : ld_data;
                    if (!req_wr_en_i && (err_code == 2'b00) && (RD_LATENCY > 1)) begin
                        state_d = ST_WAIT;
                        cnt_d   = 3'd1;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == LAST) begin
                    state_d = ST_RESP;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                    data_d  = 32'd0;
                    err_d   = 2'b00;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            data_q  <= 32'd0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dmem_hs_ctrl.sv
// Bench for dmem_hs_ctrl (RD_LATENCY=3): directed vectors then random traffic
// against a byte-array reference model.
module tb_dmem_hs_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wr_en, req_zero_extend;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wr_data;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rd_data;
    logic [1:0]  rsp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [0:255];

    always #5 clk = ~clk;

    dmem_hs_ctrl #(.ADDR_WIDTH(16), .RD_LATENCY(LAT), .CHECK_ALIGN(1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_wr_en_i(req_wr_en), .req_size_i(req_size),
        .req_zero_extend_i(req_zero_extend), .req_addr_i(req_addr),
        .req_wr_data_i(req_wr_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rd_data_o(rsp_rd_data), .rsp_err_o(rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: size in bytes = 1<<sz, little-endian byte array.
    task automatic model(input bit wr, input logic [1:0] sz, input bit zx,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] ed, output logic [1:0] ee);
        int nb;
        nb = 1 << sz;
        ed = 32'd0;
        ee = 2'b00;
        if ((a % nb) != 0) ee = 2'b01;
        else if (a >= 32'h10000) ee = 2'b10;
        else if (wr) begin
            for (int i = 0; i < nb; i++) ref_mem[a + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < nb; i++) ed[8*i +: 8] = ref_mem[a + i];
            if (nb < 4 && !zx && ed[8*nb-1]) ed = ed | ~((32'h1 << (8*nb)) - 1);
        end
    endtask

    task automatic txn(input bit wr, input logic [1:0] sz, input bit zx,
                       input logic [31:0] a, input logic [31:0] wd, input int hold,
                       output logic [31:0] got_d, output logic [1:0] got_e);
        logic [31:0] ed;
        logic [1:0]  ee;
        int n;
        model(wr, sz, zx, a, wd, ed, ee);
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        check("req_ready_idle", req_ready, 1);
        req_valid = 1; req_wr_en = wr; req_size = sz; req_zero_extend = zx;
        req_addr = a; req_wr_data = wd;
        @(posedge clk);
        #1;
        req_valid = $urandom_range(0, 1); req_wr_en = $urandom_range(0, 1);
        req_size = 2'($urandom_range(0, 2)); req_zero_extend = $urandom_range(0, 1);
        req_addr = $urandom; req_wr_data = $urandom;
        n = 1;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        check("latency", n, (!wr && ee == 2'b00) ? LAT : 1);
        check("rsp_data", rsp_rd_data, ed);
        check("rsp_err", {30'd0, rsp_err}, {30'd0, ee});
        check("req_ready_busy", req_ready, 0);
        got_d = rsp_rd_data;
        got_e = rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_data", rsp_rd_data, ed);
            check("hold_err", {30'd0, rsp_err}, {30'd0, ee});
        end
        rsp_ready = 1;
        req_valid = 0;
        @(negedge clk);
        check("rsp_done", rsp_valid, 0);
        rsp_ready = 0;
    endtask

    logic [31:0] d;
    logic [1:0]  e;
    logic [31:0] ra, rw;

    initial begin
        rst_n = 0; req_valid = 0; req_wr_en = 0; req_size = 0; req_zero_extend = 0;
        req_addr = 0; req_wr_data = 0; rsp_ready = 0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_data", rsp_rd_data, 0);
        check("rst_err", {30'd0, rsp_err}, 0);
        rst_n = 1;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1);

        for (int w = 0; w < 64; w++) txn(1, 2'd2, 0, 32'(w * 4), $urandom, 0, d, e);

        txn(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, d, e);
        txn(0, 2'd2, 0, 32'h10, 0, 1, d, e);
        check("t1_word", d, 32'hDEADBEEF);
        txn(0, 2'd0, 0, 32'h13, 0, 0, d, e);
        check("t2_byte_s", d, 32'hFFFFFFDE);
        txn(0, 2'd0, 1, 32'h13, 0, 0, d, e);
        check("t2_byte_z", d, 32'h000000DE);
        txn(0, 2'd1, 0, 32'h12, 0, 0, d, e);
        check("t2_half_s", d, 32'hFFFFDEAD);
        txn(0, 2'd2, 0, 32'h10, 0, 5, d, e);
        check("t3_hold5", d, 32'hDEADBEEF);
        txn(0, 2'd2, 0, 32'h11, 0, 0, d, e);
        check("t4_mis", {30'd0, e}, 1);
        txn(0, 2'd2, 0, 32'h0, 0, 0, ra, e);
        txn(1, 2'd1, 0, 32'h10000, 32'h5A5A, 0, d, e);
        check("t4_oor", {30'd0, e}, 2);
        txn(0, 2'd2, 0, 32'h0, 0, 0, d, e);
        check("t4_unchanged", d, ra);
        txn(1, 2'd2, 0, 32'h20, 32'h11223344, 0, d, e);
        txn(1, 2'd0, 0, 32'h21, 32'h000000AA, 0, d, e);
        txn(0, 2'd2, 0, 32'h20, 0, 0, d, e);
        check("t5_byte_merge", d, 32'h1122AA44);

        // Reset while a load is in its latency window.
        @(negedge clk);
        req_valid = 1; req_wr_en = 0; req_size = 2'd2; req_addr = 32'h20;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        check("t6_waiting", rsp_valid, 0);
        #1 rst_n = 0;
        #1;
        check("t6_rst_valid", rsp_valid, 0);
        check("t6_rst_ready", req_ready, 0);
        check("t6_rst_data", rsp_rd_data, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("t6_ready_after", req_ready, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t6_dropped", rsp_valid, 0);
        end
        txn(0, 2'd2, 0, 32'h20, 0, 0, d, e);
        check("t6_ram_kept", d, 32'h1122AA44);

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 7) == 0)
                ra = ($urandom_range(1, 32'hFFFF) << 16) | $urandom_range(0, 255);
            else
                ra = $urandom_range(0, 255);
            rw = $urandom;
            txn($urandom_range(0, 1), 2'($urandom_range(0, 2)), $urandom_range(0, 1),
                ra, rw, $urandom_range(0, 3), d, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout got=%0d exp=%0d", checks, 0);
        $fatal(1);
    end

endmodule
